i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S transmitter: the playback-side counterpart of the microphone capture path.
- Accepts stereo PCM sample pairs over a valid/ready handshake.
- Serialises them MSB-first onto an I2S link (bit clock, word select, serial data) that drives an external DAC or class-D amplifier.
- Generates its own bit clock from the system clock.

Parameters:
- DATA_W, 16: PCM sample width per channel, 2..SLOT_W-1.
- SLOT_W, 32: bit-clock periods per channel slot; frame = 2*SLOT_W bits.
- CLK_DIV, 4: clk cycles per half period of mclk, >=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  enable streaming.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  holding buffer can accept a pair.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- mclk  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left slot, 1 = right slot.
- sd  out  1  serial data.
- busy  out  1  high in RUN state.
- underrun  out  1  one-cycle pulse when a frame starts with an empty buffer.

Behaviour:
- Reset (reset=0, async): all outputs and state cleared.
  - mclk=0, ws=0, sd=0, s_ready=1, busy=0, underrun=0.
  - Buffer empty; state IDLE.
- Holding buffer: one entry, holds {left,right}.
  - s_ready = !buf_full.
  - Transfer occurs when s_valid && s_ready; buffer becomes full next cycle.
  - s_ready is registered-equivalent: it must not depend combinationally on s_valid.
- Divider: count 0..CLK_DIV-1 in RUN; mclk toggles when the count wraps.
  - "fall" strobe = the cycle mclk goes 1->0.
  - "rise" strobe = the cycle mclk goes 0->1.
- States:
  - IDLE: mclk=0, ws=0, sd=0, divider held at 0. Go to RUN when en=1 and buf_full.
  - RUN: free-running mclk.
    - Frame bit counter f runs 0..2*SLOT_W-1 and advances on each fall.
    - On exit, return to IDLE when f wraps to 0 with en=0.
- Entering RUN (transition cycle):
  - f=0.
  - Shift register loaded from the buffer; buffer cleared.
  - ws=0, sd=0, mclk=0.
  - First rise occurs CLK_DIV cycles later.
- Outputs update only on fall cycles, or on the RUN-entry cycle. The DAC samples on rise.
  - ws = (f >= SLOT_W).
  - Slot index b = f mod SLOT_W.
  - sd = channel bit (DATA_W-b) for 1 <= b <= DATA_W, else 0.
  - Result: the MSB appears one bit after each ws transition (Philips I2S).
- Frame boundary (fall where f wraps to 0, en=1):
  - If buf_full: load the shift register from the buffer and clear the buffer.
  - Else: load zeros and pulse underrun for exactly one clk cycle.
  - A pair accepted on that same cycle goes into the buffer and is used next frame; the frame is still an underrun.
- en deasserted mid-frame: the current frame completes, then IDLE. The buffer is retained.
- en=1 with empty buffer in IDLE: stay IDLE, no underrun.
- Reset mid-frame: immediate abort, all state to reset values, buffer contents discarded.
- Throughput: one pair per 4*SLOT_W*CLK_DIV clk cycles.

Optional Feature:
- Macro: I2S_HOLD_LAST_EN.
- Defined: on underrun the shift register reloads the previously transmitted pair instead of zeros. underrun still pulses.
- Undefined: zeros are sent on underrun. Reset value of the "last pair" register is zero.

Decomposition:
- Package i2s_pkg holds:
  - state enum (IDLE, RUN);
  - localparam FRAME_W = 2*SLOT_W;
  - counter width derivations: clog2 of FRAME_W and of CLK_DIV.
- One natural sub-module, i2s_clkgen: the divider, producing mclk plus the rise and fall strobes, with enable and async active-low reset.
- Buffer, frame counter and shifter stay in i2s_tx.

Test Plan:
- Reset values: reset=0 asserted mid-stream, asynchronously between clk edges.
  - Outputs go immediately to mclk=0, ws=0, sd=0, s_ready=1, busy=0, underrun=0.
  - After release, IDLE until a pair is offered.
- Basic frame: DATA_W=16, SLOT_W=32, CLK_DIV=2; left=16'hA5F0, right=16'h0F0F; en=1.
  - sd sampled on mclk rises: ws=0 bits 0..31 read 0,1010010111110000, then 15 zeros.
  - ws=1 bits 32..63 read 0,0000111100001111, then 15 zeros.
  - Frame length is 256 clk cycles.
- Back-to-back: offer a new pair every frame with s_valid held high.
  - s_ready drops for exactly the buffer-full interval.
  - No underrun; consecutive frames carry the pairs in order.
- Underrun: stop offering after one pair.
  - The next frame boundary shows a 1-cycle underrun.
  - The following frame carries all zeros, or repeats the last pair with I2S_HOLD_LAST_EN.
- Simultaneous accept at boundary: drive s_valid on the exact wrap/fall cycle with the buffer empty.
  - underrun pulses; the pair appears in the following frame.
- Enable drop: en=0 at frame bit 20.
  - Frame completes to bit 63, then busy=0 and mclk stays at 0.
  - A buffered pair is retained and sent when en returns to 1.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and width helpers for the I2S transmitter.
// The optional I2S_HOLD_LAST_EN macro is consumed by i2s_tx.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int SLOT_W_DEF  = 32;
  localparam int CLK_DIV_DEF = 4;
  localparam int FRAME_W     = 2 * SLOT_W_DEF;

  // Counter width for a count of n states; never narrower than one bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: mclk toggles every CLK_DIV clk cycles while enabled,
// with single-cycle rise/fall strobes marking the clk cycle of each toggle.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_mclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW     = ctr_w(CLK_DIV);
  localparam logic [CW-1:0] L_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_mclk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == L_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_mclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_mclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_mclk <= ~r_mclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_mclk = r_mclk;
  assign o_rise = w_wrap && !r_mclk;
  assign o_fall = w_wrap && r_mclk;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-pair holding buffer, frame counter, shifter.
// Define I2S_HOLD_LAST_EN to repeat the previous pair on underrun instead of zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              mclk,
  output logic              ws,
  output logic              sd,
  output logic              busy,
  output logic              underrun
);

  localparam int             L_FRAME_W = 2 * SLOT_W;
  localparam int             FCW       = ctr_w(L_FRAME_W);
  localparam logic [FCW-1:0] L_F_LAST  = FCW'(L_FRAME_W - 1);
  localparam logic [FCW-1:0] L_SLOT    = FCW'(SLOT_W);

  state_t                 r_state, w_state_nxt;
  logic                   r_buf_full;
  logic [DATA_W-1:0]      r_buf_l, r_buf_r;
  logic [L_FRAME_W-1:0]   r_sh, w_frame_buf, w_frame_fill;
  logic [FCW-1:0]         r_f, w_f_nxt;
  logic                   r_ws, r_sd, r_underrun;
  logic                   w_rise, w_fall;
  logic                   w_start, w_bound, w_wrap_go;
  logic                   w_accept, w_load_buf, w_underrun;

  i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk     (clk),
    .i_rst_n (reset),
    .i_en    (r_state == RUN),
    .o_mclk  (mclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_start    = (r_state == IDLE) && en && r_buf_full;
  assign w_bound    = w_fall && (r_f == L_F_LAST);
  assign w_wrap_go  = w_bound && en;
  assign w_accept   = s_valid && !r_buf_full;
  assign w_load_buf = w_start || (w_wrap_go && r_buf_full);
  assign w_underrun = w_wrap_go && !r_buf_full;
  assign w_f_nxt    = r_f + 1'b1;

  // Whole frame laid out MSB-first: slot bit 0 is the Philips one-bit delay.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_frame_buf                        = '0;
    w_frame_buf[L_FRAME_W-2 -: DATA_W] = r_buf_l;
    w_frame_buf[SLOT_W-2 -: DATA_W]    = r_buf_r;
  end

`ifdef I2S_HOLD_LAST_EN
  logic [L_FRAME_W-1:0] r_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_last <= '0;
    else if (w_load_buf) r_last <= w_frame_buf;
  end

  assign w_frame_fill = r_last;
`else
  assign w_frame_fill = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start)           w_state_nxt = RUN;
      RUN:  if (w_bound && !en)    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: buffer data and shifter are cleared as well, so a pair aborted
      // by reset can never reappear in a later frame.
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
      r_sh       <= '0;
      r_f        <= '0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun;

      if (w_load_buf) begin
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_l    <= s_left;
        r_buf_r    <= s_right;
      end

      if (w_start || w_bound) begin
        r_f  <= '0;
        r_ws <= 1'b0;
        r_sd <= 1'b0;
      end else if (w_fall) begin
        r_f  <= w_f_nxt;
        r_ws <= (w_f_nxt >= L_SLOT);
        r_sd <= r_sh[L_FRAME_W-2];
        r_sh <= r_sh << 1;
      end

      if (w_load_buf)      r_sh <= w_frame_buf;
      else if (w_underrun) r_sh <= w_frame_fill;
    end
  end

  // The DAC samples on rise, so a rise must never coincide with an update.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset) !(w_rise && w_fall));

  assign s_ready  = !r_buf_full;
  assign ws       = r_ws;
  assign sd       = r_sd;
  assign busy     = (r_state == RUN);
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (DATA_W=16, SLOT_W=32, CLK_DIV=2): frame table,
// back-to-back flow, underrun, boundary accept, enable drop, async reset.
module tb_i2s_tx;

  localparam int DATA_W  = 16;
  localparam int SLOT_W  = 32;
  localparam int CLK_DIV = 2;

  logic              clk, reset, en, s_valid, s_ready;
  logic [DATA_W-1:0] s_left, s_right;
  logic              mclk, ws, sd, busy, underrun;

  i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .mclk     (mclk),
    .ws       (ws),
    .sd       (sd),
    .busy     (busy),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          waits;
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl[8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] frames[$];
  int          ws_err = 0, und_pulses = 0, und_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sd/ws sampled at the first negedge after each mclk rise.
  initial begin
    logic        prev_mclk, prev_und;
    int          idx;
    logic [63:0] bits;
    prev_mclk = 1'b0;
    prev_und  = 1'b0;
    idx       = 0;
    bits      = '0;
    forever begin
      @(negedge clk);
      if (underrun === 1'b1) und_cycles++;
      if (underrun === 1'b1 && !prev_und) und_pulses++;
      prev_und = (underrun === 1'b1);
      if (!reset || !busy) begin
        idx  = 0;
        bits = '0;
      end else if (mclk && !prev_mclk) begin
        bits = {bits[62:0], sd};
        if (ws !== (idx >= SLOT_W)) ws_err++;
        idx++;
        if (idx == 2 * SLOT_W) begin
          frames.push_back(bits);
          idx = 0;
        end
      end
      prev_mclk = mclk;
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int waits);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    waits   = 0;
    while (!s_ready && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    @(negedge clk);
  endtask

  task automatic wait_underrun(input int max);
    int k;
    k = 0;
    while (!underrun && k < max) begin
      @(negedge clk);
      k++;
    end
    check("underrun_seen", 64'(underrun), 64'd1);
  endtask

  task automatic wait_frames(input int n, input int max);
    int k;
    k = 0;
    while (frames.size() < n && k < max) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("frames_%0d_arrived", n), 64'(frames.size() >= n), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mclk"},     64'(mclk),     64'd0);
    check({tag, "_ws"},       64'(ws),       64'd0);
    check({tag, "_sd"},       64'(sd),       64'd0);
    check({tag, "_s_ready"},  64'(s_ready),  64'd1);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_underrun"}, 64'(underrun), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;

    // Frame image: {0, left, 15 zeros, 0, right, 15 zeros}, MSB = frame bit 0.
    tbl[0] = '{16'hA5F0, 16'h0F0F, 0,   64'h52F80000_07878000};
    tbl[1] = '{16'h7FFF, 16'h8000, 1,   64'h3FFF8000_40000000};
    tbl[2] = '{16'h8000, 16'h7FFF, 255, 64'h40000000_3FFF8000};
    tbl[3] = '{16'h0001, 16'h8001, 255, 64'h00008000_40008000};
`ifdef I2S_HOLD_LAST_EN
    tbl[4] = '{16'h0000, 16'h0000, 0,   64'h00008000_40008000};
    tbl[5] = '{16'h0000, 16'h0000, 0,   64'h00008000_40008000};
`else
    tbl[4] = '{16'h0000, 16'h0000, 0,   64'h00000000_00000000};
    tbl[5] = '{16'h0000, 16'h0000, 0,   64'h00000000_00000000};
`endif
    tbl[6] = '{16'h1234, 16'hABCD, 0,   64'h091A0000_55E68000};
    tbl[7] = '{16'hFFFF, 16'h0001, 0,   64'h7FFF8000_00008000};

    reset   = 1'b0;
    en      = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    reset = 1'b1;
    en    = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_empty_busy", 64'(busy), 64'd0);
    check("idle_empty_mclk", 64'(mclk), 64'd0);

    // Back-to-back pairs with s_valid held high.
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].l, tbl[i].r, w);
      check($sformatf("ready_wait_%0d", i), 64'(w), 64'(tbl[i].waits));
    end
    s_valid = 1'b0;

    wait_underrun(1200);
    check("no_underrun_before_frame4", 64'(frames.size()), 64'd4);

    // Pair offered on the exact boundary edge of frame 5 with an empty buffer.
    repeat (255) @(negedge clk);
    s_left  = tbl[6].l;
    s_right = tbl[6].r;
    s_valid = 1'b1;
    check("bound_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    check("bound_underrun", 64'(underrun), 64'd1);
    check("bound_buffered", 64'(s_ready), 64'd0);

    repeat (256) @(negedge clk);
    check("frame6_no_underrun", 64'(underrun), 64'd0);
    check("frame6_buf_free", 64'(s_ready), 64'd1);

    // Enable drop at frame bit 20 with a pair waiting in the buffer.
    send(tbl[7].l, tbl[7].r, w);
    s_valid = 1'b0;
    check("p5_wait", 64'(w), 64'd0);
    repeat (79) @(negedge clk);
    en = 1'b0;
    n  = 80;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("en_drop_frame_len", 64'(n), 64'd256);
    repeat (30) @(negedge clk);
    check("en_off_busy", 64'(busy), 64'd0);
    check("en_off_mclk", 64'(mclk), 64'd0);
    check("en_off_retained", 64'(s_ready), 64'd0);
    check("en_off_underruns", 64'(und_pulses), 64'd2);

    en = 1'b1;
    wait_frames(8, 400);
    wait_underrun(100);

    // Async reset mid-frame (slot bit 32: ws=1, mclk=1) with a pair buffered.
    send(tbl[0].l, tbl[0].r, w);
    s_valid = 1'b0;
    repeat (129) @(negedge clk);
    check("pre_reset_ws", 64'(ws), 64'd1);
    check("pre_reset_mclk", 64'(mclk), 64'd1);
    check("pre_reset_underruns", 64'(und_pulses), 64'd3);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_mclk", 64'(mclk), 64'd0);
    check("post_reset_buf_discarded", 64'(s_ready), 64'd1);

    send(tbl[1].l, tbl[1].r, w);
    s_valid = 1'b0;
    check("post_reset_accept_full", 64'(s_ready), 64'd0);
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("post_reset_start_latency", 64'(n), 64'd1);

    // Frame contents in order.
    check("frame_count", 64'(frames.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frame_%0d_bits", i), (i < frames.size()) ? frames[i] : 64'hx, tbl[i].exp);
    end
    check("ws_pattern_errors", 64'(ws_err), 64'd0);
    check("underrun_total", 64'(und_pulses), 64'd3);
    check("underrun_one_cycle", 64'(und_cycles), 64'(und_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
